puf_response_sequencer: RTL
===========================

// Module: puf_response_sequencer
// PURPOSE
//  Downstream controller for the two post-mux ring-oscillator counters (A, B).
//  For each challenge index it clears both counters and enables them.
//  It then detects which counter finishes first and records one response bit.
//  After RESP_BITS challenges it presents the full response word with a valid/ready handshake.
// PARAMETERS
//  CNT_W        22     width of counter values cnt_a/cnt_b
//  RESP_BITS    32     response bits per run; one challenge per bit
//  SEL_W        5      challenge-select width; 2**SEL_W >= RESP_BITS
//  TIMEOUT_CYC  65535  max RUN cycles before a bit is forced to 0 and err is set
//  MARGIN       8      min count difference for a stable bit (PUF_MARGIN_EN only)
// PORTS
//  clk         in   1          clock
//  reset       in   1          asynchronous, active-high reset
//  start       in   1          begin a run; sampled in IDLE only
//  cnt_a       in   CNT_W      counter A value
//  fin_a       in   1          counter A finished
//  cnt_b       in   CNT_W      counter B value
//  fin_b       in   1          counter B finished
//  cnt_clear   out  1          reset pulse to both counters
//  cnt_enable  out  1          enable to both counters
//  sel         out  SEL_W      current challenge index to the RO muxes
//  resp        out  RESP_BITS  response word; bit i = challenge i
//  resp_valid  out  1          resp stable and held until accepted
//  resp_ready  in   1          consumer accepts resp
//  busy        out  1          high in every state except IDLE
//  err         out  1          sticky per run; set if any challenge timed out
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal timer and index cleared. Reset mid-run aborts the run; no partial resp.
//  FSM: IDLE -start-> CLEAR (1 cyc: cnt_clear=1, timer=0) -> RUN (cnt_enable=1) -> COMPARE (1 cyc) -> NEXT (1 cyc).
//   NEXT -> CLEAR if sel<RESP_BITS-1 (sel++), else -> DONE.
//   DONE: resp_valid=1 until resp_valid&&resp_ready, then IDLE with sel=0 on the next cycle.
//  RUN exits on the first cycle with (fin_a||fin_b) or timer==TIMEOUT_CYC-1.
//   cnt_a/cnt_b/fin_a/fin_b are latched on that exit cycle; cnt_enable drops in COMPARE.
//  Bit rule from latched values:
//   fin_a&!fin_b -> 1; fin_b&!fin_a -> 0; both set -> (cnt_a>cnt_b); neither set (timeout) -> 0 and err=1.
//  resp[sel] written in COMPARE; resp cleared on entry to CLEAR when sel==0.
//  Per-bit latency = 3 + RUN cycles.
//  start is ignored while busy. resp_ready is ignored outside DONE.
//  Comparison is unsigned over CNT_W; the difference is computed CNT_W+1 wide with no wrap.
// CONFIGURATION
//  PUF_MARGIN_EN defined:
//   adds output `unstable` [RESP_BITS] (reset 0), cleared at run start.
//   unstable[sel]=1 if |cnt_a-cnt_b| < MARGIN at the latch cycle, or on timeout.
//  PUF_MARGIN_EN undefined: no `unstable` port and no subtractor; MARGIN unused.
// STRUCTURE
//  puf_pkg: state enum (IDLE, CLEAR, RUN, COMPARE, NEXT, DONE) and CNT_W default.
//  Sub-module puf_race_detector: latch, bit-decision and margin logic (combinational + latch regs).
//  The FSM, timer and sel counter stay in this module.
// TESTING
//  1 RESP_BITS=4; fin_a 10 cyc before fin_b on every challenge -> resp=4'b1111, err=0, sel steps 0..3.
//  2 Alternate winners B,A,B,A -> resp=4'b1010; cnt_clear pulses exactly once per challenge.
//  3 fin_a=fin_b same cycle with cnt_a=512, cnt_b=511 -> bit=1.
//    With PUF_MARGIN_EN and MARGIN=8 -> unstable bit set.
//  4 Hold fins low, TIMEOUT_CYC=16 -> RUN exits after 16 cyc; bit=0, err=1 until next start.
//  5 resp_ready low for 5 cyc in DONE -> resp_valid and resp held constant; start pulses ignored.
//  6 Assert reset during RUN at sel=2 -> all outputs 0 same cycle; next start restarts at sel=0.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the RO-PUF response sequencer.
package puf_pkg;

    localparam int CNT_W_DEF     = 22;
    localparam int RESP_BITS_DEF = 32;
    localparam int SEL_W_DEF     = 5;
    localparam int TIMEOUT_DEF   = 65535;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        COMPARE,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/puf_race_detector.sv
// Captures the counter race outcome and derives the response bit from the captured values.
// With PUF_MARGIN_EN defined it also flags races closer than MARGIN counts as unstable.
module puf_race_detector
    import puf_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF
`ifdef PUF_MARGIN_EN
    ,
    parameter int MARGIN = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             latch_en,
    input  logic [CNT_W-1:0] cnt_a,
    input  logic             fin_a,
    input  logic [CNT_W-1:0] cnt_b,
    input  logic             fin_b,
    output logic             race_bit,
    output logic             timeout
`ifdef PUF_MARGIN_EN
    ,
    output logic             unstable
`endif
);

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             fin_a_q, fin_a_d;
    logic             fin_b_q, fin_b_d;

    always_comb begin
        cnt_a_d = latch_en ? cnt_a : cnt_a_q;
        cnt_b_d = latch_en ? cnt_b : cnt_b_q;
        fin_a_d = latch_en ? fin_a : fin_a_q;
        fin_b_d = latch_en ? fin_b : fin_b_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            fin_a_q <= 1'b0;
            fin_b_q <= 1'b0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            fin_a_q <= fin_a_d;
            fin_b_q <= fin_b_d;
        end
    end

    // A tie on the finish flags is broken by the larger captured count.
    always_comb begin
        race_bit = 1'b0;
        unique case ({fin_a_q, fin_b_q})
            2'b10:   race_bit = 1'b1;
            2'b01:   race_bit = 1'b0;
            2'b11:   race_bit = (cnt_a_q > cnt_b_q);
            default: race_bit = 1'b0;
        endcase
    end

    assign timeout = !fin_a_q && !fin_b_q;

`ifdef PUF_MARGIN_EN
    logic [CNT_W:0] diff;

    always_comb begin
        if (cnt_a_q >= cnt_b_q) diff = {1'b0, cnt_a_q} - {1'b0, cnt_b_q};
        else                    diff = {1'b0, cnt_b_q} - {1'b0, cnt_a_q};
        unstable = timeout || (diff < (CNT_W + 1)'(MARGIN));
    end
`endif

endmodule

// File: rtl/puf_response_sequencer.sv
// Steps through RESP_BITS challenges, races counters A/B per challenge and hands off the response word.
// Define PUF_MARGIN_EN to add the per-bit `unstable` output and the MARGIN parameter.
module puf_response_sequencer
    import puf_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int RESP_BITS   = RESP_BITS_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
`ifdef PUF_MARGIN_EN
    ,
    parameter int MARGIN      = 8
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic                 fin_a,
    input  logic [CNT_W-1:0]     cnt_b,
    input  logic                 fin_b,
    output logic                 cnt_clear,
    output logic                 cnt_enable,
    output logic [SEL_W-1:0]     sel,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy,
    output logic                 err
`ifdef PUF_MARGIN_EN
    ,
    output logic [RESP_BITS-1:0] unstable
`endif
);

    localparam int               TMR_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(RESP_BITS - 1);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 err_q, err_d;
    logic                 cnt_clear_q, cnt_clear_d;
    logic                 cnt_enable_q, cnt_enable_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 busy_q, busy_d;

    logic run_exit;
    logic latch_en;
    logic race_bit;
    logic race_timeout;

    // Exit cycle is the one on which the detector captures the counters.
    assign run_exit = fin_a || fin_b || (timer_q == TIMER_LAST);
    assign latch_en = (state_q == RUN) && run_exit;

`ifdef PUF_MARGIN_EN
    logic [RESP_BITS-1:0] unstable_q, unstable_d;
    logic                 race_unstable;

    puf_race_detector #(
        .CNT_W   (CNT_W),
        .MARGIN  (MARGIN)
    ) u_race (
        .clk      (clk),
        .reset    (reset),
        .latch_en (latch_en),
        .cnt_a    (cnt_a),
        .fin_a    (fin_a),
        .cnt_b    (cnt_b),
        .fin_b    (fin_b),
        .race_bit (race_bit),
        .timeout  (race_timeout),
        .unstable (race_unstable)
    );
`else
    puf_race_detector #(
        .CNT_W   (CNT_W)
    ) u_race (
        .clk      (clk),
        .reset    (reset),
        .latch_en (latch_en),
        .cnt_a    (cnt_a),
        .fin_a    (fin_a),
        .cnt_b    (cnt_b),
        .fin_b    (fin_b),
        .race_bit (race_bit),
        .timeout  (race_timeout)
    );
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        resp_d  = resp_q;
        err_d   = err_q;
`ifdef PUF_MARGIN_EN
        unstable_d = unstable_q;
`endif

        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                if (start) begin
                    state_d = CLEAR;
                    err_d   = 1'b0;
`ifdef PUF_MARGIN_EN
                    unstable_d = '0;
`endif
                end
            end
            CLEAR: begin
                timer_d = '0;
                state_d = RUN;
            end
            RUN: begin
                timer_d = timer_q + 1'b1;
                if (run_exit) state_d = COMPARE;
            end
            COMPARE: begin
                resp_d[sel_q] = race_bit;
                if (race_timeout) err_d = 1'b1;
`ifdef PUF_MARGIN_EN
                unstable_d[sel_q] = race_unstable;
`endif
                state_d = NEXT;
            end
            NEXT: begin
                if (sel_q < LAST_SEL) begin
                    sel_d   = sel_q + 1'b1;
                    state_d = CLEAR;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh run starts from an all-zero word.
        if (state_d == CLEAR && state_q != CLEAR && sel_d == '0) resp_d = '0;

        cnt_clear_d  = (state_d == CLEAR);
        cnt_enable_d = (state_d == RUN);
        resp_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            timer_q      <= '0;
            resp_q       <= '0;
            err_q        <= 1'b0;
            cnt_clear_q  <= 1'b0;
            cnt_enable_q <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PUF_MARGIN_EN
            unstable_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            timer_q      <= timer_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            cnt_clear_q  <= cnt_clear_d;
            cnt_enable_q <= cnt_enable_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
`ifdef PUF_MARGIN_EN
            unstable_q   <= unstable_d;
`endif
        end
    end

    assign cnt_clear  = cnt_clear_q;
    assign cnt_enable = cnt_enable_q;
    assign sel        = sel_q;
    assign resp       = resp_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;
`ifdef PUF_MARGIN_EN
    assign unstable   = unstable_q;
`endif

endmodule
